muldiv_writeback_unit: RTL and testbench
========================================

Name: muldiv_writeback_unit

Overview:
Iterative 64-bit multiply/divide unit between the register file read ports and its write port. It consumes the two 64-bit register read values, computes MUL, UMULH, UDIV or SDIV over multiple cycles, and drives the register file write port for one cycle. Busy/Done let the single-cycle control logic stall the PC while an operation runs.

Parameters:
DATA_W, 64, operand/result width; only 64 is required to work
REG_AW, 5, register address width
ZERO_REG, 31, index of XZR; writes to it are suppressed

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  synchronous, active-high reset
Start  input  1  launch request; sampled only in IDLE
Op  input  2  00=MUL (low 64), 01=UMULH (high 64, unsigned), 10=UDIV, 11=SDIV
OpA  input  DATA_W  first operand (register file Out1); dividend for divides
OpB  input  DATA_W  second operand (register file Out2); divisor for divides
DestReg  input  REG_AW  destination register index
Busy  output  1  high from the cycle after accepted Start through the WRITE cycle
Done  output  1  one-cycle pulse in the WRITE cycle
WReg  output  REG_AW  register file write address
Data  output  DATA_W  register file write data
WE  output  1  register file write-enable

Behaviour:
- One clock, Clk. Reset is synchronous and active-high. On Reset: state IDLE; Busy, Done, WE = 0; WReg = 0; Data = 0; counter = 0. Reset overrides Start.
- Reset during CALC/WRITE aborts the operation. No WE is issued. Outputs are 0 from the next cycle.
- States: IDLE -> CALC -> WRITE -> IDLE.
- IDLE: Start=1 latches Op, OpA, OpB, DestReg. Next state is CALC, or WRITE for a divide by zero.
- Start while Busy=1 is ignored. Latched operands are unaffected by later input changes.
- CALC: exactly DATA_W cycles, one bit per cycle, using a 6-bit counter 0..63. Moves to WRITE when the counter reaches 63.
- MUL/UMULH: unsigned shift-add into a 128-bit accumulator. MUL returns bits [63:0]; UMULH returns bits [127:64]. MUL is sign-agnostic.
- UDIV: restoring divide, unsigned, truncated quotient. The remainder is discarded.
- SDIV: divide magnitudes unsigned, then negate the quotient if sign(OpA) XOR sign(OpB). Rounds toward zero.
- SDIV 0x8000000000000000 / -1 = 0x8000000000000000, with no trap.
- Divide by zero (OpB=0, Op=1x): result 0 per ARMv8. CALC is skipped, giving latency 2 instead of 66.
- WRITE (one cycle): Done=1, Data=result, WReg=latched DestReg, WE=1 unless DestReg==ZERO_REG. Busy remains 1. Next state is IDLE.
- Outside WRITE: WE=0, Done=0, Data holds the last result, WReg holds the last value.
- Latency: Start sampled at edge N -> Busy=1 after N -> WE/Done high in the cycle after edge N+65. Busy falls after edge N+66.
- Start is accepted again in the first IDLE cycle after WRITE (back-to-back ops, one idle cycle between).

Decomposition:
- Shared package muldiv_pkg: Op encodings (OP_MUL, OP_UMULH, OP_UDIV, OP_SDIV), state enum (IDLE, CALC, WRITE), ZERO_REG constant.
- One natural sub-module, muldiv_step: the combinational single-iteration shift-add / shift-subtract step. The top holds the FSM, counter, sign fix-up and write-port registers.

Test Plan:
- MUL: OpA=7, OpB=6, DestReg=3 -> Busy for 66 cycles; one cycle with WE=1, WReg=3, Data=42, Done=1, at cycle 66 after Start.
- UMULH: OpA=0xFFFFFFFFFFFFFFFF, OpB=2 -> Data=1. The same operands with MUL -> Data=0xFFFFFFFFFFFFFFFE.
- Divides:
  - UDIV 100/7 -> Data=14.
  - SDIV -100/7 -> 0xFFFFFFFFFFFFFFF2 (-14).
  - SDIV 0x8000000000000000/0xFFFFFFFFFFFFFFFF -> 0x8000000000000000.
- Divide by zero: UDIV 5/0 -> WE=1, Data=0 two cycles after Start. Busy is high for exactly 2 cycles.
- Protocol:
  - Start pulsed again mid-CALC with different operands -> ignored; the first result is written unchanged.
  - DestReg=31 -> Done pulses, WE stays 0.
- Reset at CALC cycle 30 -> next cycle Busy=0, no WE ever issued. A new Start afterwards completes correctly.

Source files
------------

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings for the iterative multiply/divide writeback unit
package muldiv_pkg;

   localparam logic [1:0] OP_MUL   = 2'b00;
   localparam logic [1:0] OP_UMULH = 2'b01;
   localparam logic [1:0] OP_UDIV  = 2'b10;
   localparam logic [1:0] OP_SDIV  = 2'b11;

   localparam int ZERO_REG = 31;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      WRITE = 2'd2
   } state_t;

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational iteration of shift-add multiply or restoring divide
// {hi,lo} is the 2*DATA_W working register; b is the multiplicand or divisor.
module muldiv_step #(
   parameter int DATA_W = 64
) (
   input  logic              div_i,
   input  logic [DATA_W-1:0] hi_i,
   input  logic [DATA_W-1:0] lo_i,
   input  logic [DATA_W-1:0] b_i,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o
);

   logic [DATA_W:0] sum;
   logic [DATA_W:0] shifted;
   logic [DATA_W:0] diff;

   always_comb begin
      sum     = {1'b0, hi_i} + {1'b0, b_i};
      shifted = {hi_i, lo_i[DATA_W-1]};
      diff    = shifted - {1'b0, b_i};
      if (div_i) begin
         // Partial remainder stays below 2*b, so bit DATA_W of diff is the borrow.
         if (diff[DATA_W]) begin
            hi_o = shifted[DATA_W-1:0];
            lo_o = {lo_i[DATA_W-2:0], 1'b0};
         end else begin
            hi_o = diff[DATA_W-1:0];
            lo_o = {lo_i[DATA_W-2:0], 1'b1};
         end
      end else if (lo_i[0]) begin
         {hi_o, lo_o} = {sum, lo_i[DATA_W-1:1]};
      end else begin
         {hi_o, lo_o} = {1'b0, hi_i, lo_i[DATA_W-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_writeback_unit.sv
// rtl/muldiv_writeback_unit.sv - iterative MUL/UMULH/UDIV/SDIV driving the register file write port
// Write-port outputs are registered, so Done/WE appear the cycle after the WRITE state.
module muldiv_writeback_unit
   import muldiv_pkg::*;
#(
   parameter int DATA_W   = 64,
   parameter int REG_AW   = 5,
   parameter int ZERO_REG = muldiv_pkg::ZERO_REG
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Start,
   input  logic [1:0]        Op,
   input  logic [DATA_W-1:0] OpA,
   input  logic [DATA_W-1:0] OpB,
   input  logic [REG_AW-1:0] DestReg,
   output logic              Busy,
   output logic              Done,
   output logic [REG_AW-1:0] WReg,
   output logic [DATA_W-1:0] Data,
   output logic              WE
);

   localparam int CNT_W = $clog2(DATA_W);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [1:0]          op_q, op_d;
   logic [REG_AW-1:0]   dest_q, dest_d;
   logic                neg_q, neg_d;
   logic                dz_q, dz_d;
   logic [DATA_W-1:0]   b_q, b_d;
   logic [DATA_W-1:0]   hi_q, hi_d;
   logic [DATA_W-1:0]   lo_q, lo_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                we_q, we_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [REG_AW-1:0]   wreg_q, wreg_d;

   logic                accept, step_en, wb_en, div_zero;
   logic [DATA_W-1:0]   hi_n, lo_n, result, a_mag, b_mag;

   muldiv_step #(.DATA_W(DATA_W)) u_step (
      .div_i (op_q[1]),
      .hi_i  (hi_q),
      .lo_i  (lo_q),
      .b_i   (b_q),
      .hi_o  (hi_n),
      .lo_o  (lo_n)
   );

   always_ff @(posedge Clk) begin
      if (Reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   assign div_zero = Op[1] && (OpB == '0);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = div_zero ? WRITE : CALC;
         CALC:    if (cnt_q == CNT_W'(DATA_W - 1)) state_d = WRITE;
         WRITE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The Done cycle is already IDLE but still Busy, so Start is held off there too.
   always_comb begin
      accept  = (state_q == IDLE) && Start && !busy_q;
      step_en = (state_q == CALC);
      wb_en   = (state_q == WRITE);
   end

   always_comb begin
      a_mag = (Op == OP_SDIV && OpA[DATA_W-1]) ? -OpA : OpA;
      b_mag = (Op == OP_SDIV && OpB[DATA_W-1]) ? -OpB : OpB;
      case (op_q)
         OP_MUL:   result = lo_q;
         OP_UMULH: result = hi_q;
         OP_UDIV:  result = lo_q;
         default:  result = neg_q ? -lo_q : lo_q;
      endcase
      if (dz_q) result = '0;
   end

   always_comb begin
      op_d   = op_q;
      dest_d = dest_q;
      neg_d  = neg_q;
      dz_d   = dz_q;
      b_d    = b_q;
      hi_d   = hi_q;
      lo_d   = lo_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      done_d = wb_en;
      we_d   = wb_en && (dest_q != REG_AW'(ZERO_REG));
      data_d = data_q;
      wreg_d = wreg_q;
      if (accept) begin
         op_d   = Op;
         dest_d = DestReg;
         neg_d  = (Op == OP_SDIV) && (OpA[DATA_W-1] ^ OpB[DATA_W-1]);
         dz_d   = div_zero;
         hi_d   = '0;
         cnt_d  = '0;
         busy_d = 1'b1;
         // Multiply shifts the multiplier out of lo; divide shifts the dividend out of lo.
         lo_d   = Op[1] ? a_mag : OpB;
         b_d    = Op[1] ? b_mag : OpA;
      end else if (step_en) begin
         hi_d  = hi_n;
         lo_d  = lo_n;
         cnt_d = cnt_q + CNT_W'(1);
      end
      if (done_q) busy_d = 1'b0;
      if (wb_en) begin
         data_d = result;
         wreg_d = dest_q;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         cnt_q  <= '0;
         op_q   <= '0;
         dest_q <= '0;
         neg_q  <= 1'b0;
         dz_q   <= 1'b0;
         b_q    <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         we_q   <= 1'b0;
         data_q <= '0;
         wreg_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         op_q   <= op_d;
         dest_q <= dest_d;
         neg_q  <= neg_d;
         dz_q   <= dz_d;
         b_q    <= b_d;
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         busy_q <= busy_d;
         done_q <= done_d;
         we_q   <= we_d;
         data_q <= data_d;
         wreg_q <= wreg_d;
      end
   end

   assign Busy = busy_q;
   assign Done = done_q;
   assign WE   = we_q;
   assign Data = data_q;
   assign WReg = wreg_q;

endmodule

// File: tb/tb_muldiv_writeback_unit.sv
// tb/tb_muldiv_writeback_unit.sv - scoreboard bench for muldiv_writeback_unit
module tb_muldiv_writeback_unit;
   import muldiv_pkg::*;

   typedef struct {
      logic [63:0] data;
      logic [4:0]  wreg;
      logic        we;
      int          cyc;
      string       name;
   } exp_t;

   logic        Clk = 1'b0;
   logic        Reset, Start, Busy, Done, WE;
   logic [1:0]  Op;
   logic [63:0] OpA, OpB, Data;
   logic [4:0]  DestReg, WReg;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t sb_q[$];

   muldiv_writeback_unit #(.DATA_W(64), .REG_AW(5), .ZERO_REG(31)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .OpA(OpA), .OpB(OpB),
      .DestReg(DestReg), .Busy(Busy), .Done(Done), .WReg(WReg), .Data(Data), .WE(WE)
   );

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Monitor: every Done pulse is matched against the oldest expected writeback.
   always @(negedge Clk) begin
      if (WE && !Done) chk("we_without_done", {63'b0, WE}, 64'd0);
      if (Done) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_done", {63'b0, Done}, 64'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk({e.name, "_data"}, Data, e.data);
            chk({e.name, "_wreg"}, {59'b0, WReg}, {59'b0, e.wreg});
            chk({e.name, "_we"}, {63'b0, WE}, {63'b0, e.we});
            chk({e.name, "_latency"}, 64'(cyc), 64'(e.cyc));
         end
      end
   end

   task automatic run_op(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] d, input logic [63:0] exp_data, input int lat,
                         input int exp_busy, input bit disturb, input string nm);
      exp_t e;
      int   n;
      @(negedge Clk);
      Start = 1'b1; Op = op; OpA = a; OpB = b; DestReg = d;
      @(posedge Clk); #1;
      e.data = exp_data; e.wreg = d; e.we = (d != 5'd31); e.cyc = cyc + lat; e.name = nm;
      sb_q.push_back(e);
      Start = 1'b0; OpA = ~a; OpB = ~b; DestReg = ~d;
      n = 0;
      @(negedge Clk);
      while (Busy && n < 200) begin
         n++;
         if (disturb && n == 10) begin
            Start = 1'b1; Op = OP_UDIV; OpA = 64'd81; OpB = 64'd9; DestReg = 5'd12;
         end
         if (disturb && n == 11) Start = 1'b0;
         @(negedge Clk);
      end
      chk({nm, "_busy_cycles"}, 64'(n), 64'(exp_busy));
   endtask

   initial begin
      int n;
      Reset = 1'b1; Start = 1'b0; Op = 2'b00; OpA = '0; OpB = '0; DestReg = '0;
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      chk("reset_busy", {63'b0, Busy}, 64'd0);
      chk("reset_done", {63'b0, Done}, 64'd0);
      chk("reset_we", {63'b0, WE}, 64'd0);
      chk("reset_data", Data, 64'd0);
      chk("reset_wreg", {59'b0, WReg}, 64'd0);

      run_op(OP_MUL,   64'd7, 64'd6, 5'd3, 64'd42, 65, 66, 1'b0, "mul_7x6");
      run_op(OP_UMULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd1, 64'd1, 65, 66, 1'b0, "umulh_max_x2");
      run_op(OP_MUL,   64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE, 65, 66, 1'b0, "mul_max_x2");
      run_op(OP_UDIV,  64'd100, 64'd7, 5'd4, 64'd14, 65, 66, 1'b0, "udiv_100_7");
      run_op(OP_SDIV,  64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd5, 64'hFFFF_FFFF_FFFF_FFF2, 65, 66, 1'b0, "sdiv_m100_7");
      run_op(OP_SDIV,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6,
             64'h8000_0000_0000_0000, 65, 66, 1'b0, "sdiv_min_m1");
      run_op(OP_SDIV,  64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'd8, 64'hFFFF_FFFF_FFFF_FFFD, 65, 66, 1'b0, "sdiv_7_m2");
      run_op(OP_UDIV,  64'd5, 64'd0, 5'd9, 64'd0, 1, 2, 1'b0, "udiv_by_zero");
      run_op(OP_SDIV,  64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 5'd10, 64'd0, 1, 2, 1'b0, "sdiv_by_zero");
      run_op(OP_MUL,   64'd3, 64'd5, 5'd11, 64'd15, 65, 66, 1'b1, "mul_start_mid_calc");
      run_op(OP_MUL,   64'd7, 64'd6, 5'd31, 64'd42, 65, 66, 1'b0, "mul_to_xzr");

      // Abort a multiply partway through CALC; nothing may be written for it.
      @(negedge Clk);
      Start = 1'b1; Op = OP_MUL; OpA = 64'd11; OpB = 64'd13; DestReg = 5'd14;
      @(negedge Clk);
      Start = 1'b0;
      repeat (30) @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      chk("abort_busy", {63'b0, Busy}, 64'd0);
      chk("abort_we", {63'b0, WE}, 64'd0);
      chk("abort_data", Data, 64'd0);
      n = 0;
      repeat (80) begin
         @(negedge Clk);
         if (WE || Done) n++;
      end
      chk("abort_no_writeback", 64'(n), 64'd0);

      run_op(OP_UDIV, 64'd1000, 64'd10, 5'd7, 64'd100, 65, 66, 1'b0, "udiv_after_abort");

      repeat (3) @(negedge Clk);
      chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
